// File: rtl/updown_mod_counter.sv
// Up/down modulo counter (0..MAX) with prescaled enable, sync clear/load, wrap or saturate at limits.
// Outputs change one edge after inputs are sampled; no backpressure, the counter always accepts inputs.
module updown_mod_counter #(
  parameter int WIDTH    = 4,
  parameter int MAX      = 2**WIDTH-1,
  parameter int SATURATE = 0,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clear,
  output logic [WIDTH-1:0] count,
  output logic             wrap,
  output logic             sat,
  output logic             at_max,
  output logic             at_min
);

  localparam int               PW      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [WIDTH-1:0] MAX_V   = WIDTH'(MAX);
  localparam logic [PW-1:0]    PS_LAST = PW'(PRESCALE-1);

  logic [PW-1:0]    ps;
  logic [PW-1:0]    ps_nxt;
  logic [WIDTH-1:0] count_nxt;
  logic [WIDTH-1:0] load_clamped;
  logic             wrap_nxt;
  logic             sat_nxt;
  logic             step;

  assign at_max = (count == MAX_V);
  assign at_min = (count == '0);

  assign step         = en && (ps == PS_LAST);
  assign load_clamped = (load_val > MAX_V) ? MAX_V : load_val;

  always_comb begin
    count_nxt = count;
    ps_nxt    = ps;
    wrap_nxt  = 1'b0;
    sat_nxt   = 1'b0;
    if (clear) begin
      count_nxt = '0;
      ps_nxt    = '0;
    end else if (load) begin
      count_nxt = load_clamped;
      ps_nxt    = '0;
    end else if (en) begin
      if (!step) begin
        ps_nxt = ps + PW'(1);
      end else begin
        ps_nxt = '0;
        // Limit compare happens before +1/-1, so the WIDTH-bit arithmetic never overflows.
        if (up) begin
          if (!at_max) begin
            count_nxt = count + WIDTH'(1);
          end else if (SATURATE != 0) begin
            sat_nxt = 1'b1;
          end else begin
            count_nxt = '0;
            wrap_nxt  = 1'b1;
          end
        end else begin
          if (!at_min) begin
            count_nxt = count - WIDTH'(1);
          end else if (SATURATE != 0) begin
            sat_nxt = 1'b1;
          end else begin
            count_nxt = MAX_V;
            wrap_nxt  = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      ps    <= '0;
      wrap  <= 1'b0;
      sat   <= 1'b0;
    end else begin
      count <= count_nxt;
      ps    <= ps_nxt;
      wrap  <= wrap_nxt;
      sat   <= sat_nxt;
    end
  end

endmodule

// File: tb/tb_updown_mod_counter.sv
// Drives several counter configurations from one shared stimulus stream and checks them against an integer model.
module tb_updown_mod_counter;

  localparam int N = 5;
  localparam int MAXS [N] = '{15, 9, 5, 9, 1};
  localparam int SATS [N] = '{0, 0, 1, 0, 0};
  localparam int PSS  [N] = '{1, 1, 1, 3, 1};
  localparam int WS   [N] = '{4, 4, 4, 4, 1};

  logic       clk = 1'b0;
  logic       rst, en, up, load, clear;
  logic [3:0] load_val;

  logic [3:0] cnt_a [4];
  logic       cnt_1;
  logic [N-1:0] wrap_v, sat_v, max_v, min_v;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    updown_mod_counter #(
      .WIDTH(4), .MAX(MAXS[g]), .SATURATE(SATS[g]), .PRESCALE(PSS[g])
    ) u_dut (
      .clk(clk), .rst(rst), .en(en), .up(up), .load(load),
      .load_val(load_val), .clear(clear),
      .count(cnt_a[g]), .wrap(wrap_v[g]), .sat(sat_v[g]),
      .at_max(max_v[g]), .at_min(min_v[g])
    );
  end

  updown_mod_counter #(
    .WIDTH(1), .MAX(1), .SATURATE(0), .PRESCALE(1)
  ) u_dut_w1 (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load),
    .load_val(load_val[0]), .clear(clear),
    .count(cnt_1), .wrap(wrap_v[4]), .sat(sat_v[4]),
    .at_max(max_v[4]), .at_min(min_v[4])
  );

  function automatic int dut_count(input int i);
    return (i < 4) ? int'(cnt_a[i]) : int'(cnt_1);
  endfunction

  // Behavioural model: integer count, enabled-cycle tally, and flags.
  int  m_cnt [N];
  int  m_ps  [N];
  bit  m_wrap[N];
  bit  m_sat [N];
  bit  m_valid = 1'b0;

  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      int lv;
      lv = int'(load_val) % (1 << WS[i]);
      m_wrap[i] = 1'b0;
      m_sat[i]  = 1'b0;
      if (rst || clear) begin
        m_cnt[i] = 0;
        m_ps[i]  = 0;
      end else if (load) begin
        m_cnt[i] = (lv > MAXS[i]) ? MAXS[i] : lv;
        m_ps[i]  = 0;
      end else if (en) begin
        m_ps[i] = m_ps[i] + 1;
        if (m_ps[i] == PSS[i]) begin
          m_ps[i] = 0;
          if (up) begin
            if (m_cnt[i] == MAXS[i]) begin
              if (SATS[i] != 0) m_sat[i] = 1'b1;
              else begin m_cnt[i] = 0; m_wrap[i] = 1'b1; end
            end else m_cnt[i] = m_cnt[i] + 1;
          end else begin
            if (m_cnt[i] == 0) begin
              if (SATS[i] != 0) m_sat[i] = 1'b1;
              else begin m_cnt[i] = MAXS[i]; m_wrap[i] = 1'b1; end
            end else m_cnt[i] = m_cnt[i] - 1;
          end
        end
      end
    end
    if (rst) m_valid = 1'b1;
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (m_valid) begin
      for (int i = 0; i < N; i++) begin
        chk($sformatf("u%0d.count", i),  dut_count(i),   m_cnt[i]);
        chk($sformatf("u%0d.wrap", i),   int'(wrap_v[i]), int'(m_wrap[i]));
        chk($sformatf("u%0d.sat", i),    int'(sat_v[i]),  int'(m_sat[i]));
        chk($sformatf("u%0d.at_max", i), int'(max_v[i]),  int'(m_cnt[i] == MAXS[i]));
        chk($sformatf("u%0d.at_min", i), int'(min_v[i]),  int'(m_cnt[i] == 0));
      end
    end
  end

  task automatic cyc(input bit r, input bit c, input bit l, input bit e, input bit u, input int lv);
    rst = r; clear = c; load = l; en = e; up = u; load_val = 4'(lv);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; clear = 1'b0; load = 1'b0; en = 1'b0; up = 1'b0; load_val = '0;

    // Reset state
    cyc(1, 0, 0, 0, 0, 0);
    chk("rst.count", int'(cnt_a[0]), 0);
    chk("rst.at_min", int'(min_v[0]), 1);
    chk("rst.at_max", int'(max_v[0]), 0);
    chk("rst.wrap", int'(wrap_v[0]), 0);

    // Basic up count, MAX=15 wrap; prescale 3 steps on edges 3,6,9; MAX=1 toggles
    for (int k = 1; k <= 17; k++) begin
      cyc(0, 0, 0, 1, 1, 0);
      chk("up.count", int'(cnt_a[0]), k % 16);
      chk("up.wrap", int'(wrap_v[0]), (k == 16) ? 1 : 0);
      chk("up.at_max", int'(max_v[0]), (k == 15) ? 1 : 0);
      if (k == 2) chk("ps3.edge2", int'(cnt_a[3]), 0);
      if (k == 3) chk("ps3.edge3", int'(cnt_a[3]), 1);
      if (k == 6) chk("ps3.edge6", int'(cnt_a[3]), 2);
      if (k == 9) chk("ps3.edge9", int'(cnt_a[3]), 3);
      if (k == 2) chk("w1.wrap", int'(wrap_v[4]), 1);
      if (k == 6) chk("sat5.hold", int'(sat_v[2]), 1);
    end

    // Down wrap with MAX=9; load wins over an enabled step
    cyc(0, 0, 1, 1, 0, 2);
    chk("dn.load", int'(cnt_a[1]), 2);
    cyc(0, 0, 0, 1, 0, 0); chk("dn.1", int'(cnt_a[1]), 1);
    cyc(0, 0, 0, 1, 0, 0); chk("dn.0", int'(cnt_a[1]), 0);
    cyc(0, 0, 0, 1, 0, 0); chk("dn.9", int'(cnt_a[1]), 9);
    chk("dn.wrap9", int'(wrap_v[1]), 1);
    cyc(0, 0, 0, 1, 0, 0); chk("dn.8", int'(cnt_a[1]), 8);
    chk("dn.wrap8", int'(wrap_v[1]), 0);

    // Saturate at MAX=5
    cyc(0, 0, 1, 0, 1, 4);
    cyc(0, 0, 0, 1, 1, 0); chk("sat.c1", int'(cnt_a[2]), 5); chk("sat.s1", int'(sat_v[2]), 0);
    cyc(0, 0, 0, 1, 1, 0); chk("sat.c2", int'(cnt_a[2]), 5); chk("sat.s2", int'(sat_v[2]), 1);
    cyc(0, 0, 0, 1, 1, 0); chk("sat.c3", int'(cnt_a[2]), 5); chk("sat.s3", int'(sat_v[2]), 1);
    cyc(0, 0, 0, 1, 0, 0); chk("sat.c4", int'(cnt_a[2]), 4); chk("sat.s4", int'(sat_v[2]), 0);

    // Prescaler freeze: en dropped 2 cycles delays the step by 2
    cyc(1, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 1, 1, 0);
    cyc(0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 1, 1, 0); chk("freeze.e4", int'(cnt_a[3]), 0);
    cyc(0, 0, 0, 1, 1, 0); chk("freeze.e5", int'(cnt_a[3]), 1);

    // Priority and clamp
    cyc(0, 1, 1, 0, 1, 7); chk("prio.clear", int'(cnt_a[1]), 0);
    cyc(0, 0, 1, 0, 1, 15); chk("clamp.9", int'(cnt_a[1]), 9);
    chk("clamp.15", int'(cnt_a[0]), 15);
    cyc(0, 0, 0, 1, 1, 0);
    cyc(0, 0, 0, 1, 1, 0); chk("ps3.prime", int'(cnt_a[3]), 9);
    cyc(0, 0, 1, 1, 1, 3); chk("ldwin", int'(cnt_a[3]), 3);
    cyc(0, 0, 0, 1, 1, 0);
    cyc(0, 0, 0, 1, 1, 0); chk("ldwin.e2", int'(cnt_a[3]), 3);
    cyc(0, 0, 0, 1, 1, 0); chk("ldwin.e3", int'(cnt_a[3]), 4);

    // Mid-run reset loses prescaler phase
    cyc(0, 0, 1, 0, 1, 6);
    cyc(0, 0, 0, 1, 1, 0); chk("mid.pre", int'(cnt_a[3]), 6);
    cyc(1, 0, 0, 1, 1, 0); chk("mid.rst", int'(cnt_a[3]), 0);
    chk("mid.wrap", int'(wrap_v[3]), 0);
    cyc(0, 0, 0, 1, 1, 0);
    cyc(0, 0, 0, 1, 1, 0); chk("mid.e2", int'(cnt_a[3]), 0);
    cyc(0, 0, 0, 1, 1, 0); chk("mid.e3", int'(cnt_a[3]), 1);

    // Plain clear
    cyc(0, 1, 0, 1, 1, 0); chk("clear", int'(cnt_a[0]), 0);
    cyc(0, 0, 0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/updown_mod_counter.md
# updown_mod_counter

Parametrised up/down modulo counter with prescaled enable, synchronous load/clear, and wrap or saturate behaviour at the range limits. It is the general-purpose successor to the free-running 4-bit counter. It serves as the tick/index source for mux select sequencing, timers and address generation. All state changes on the rising edge of `clk`; every output is registered or decoded directly from registered state.

## Interface
- WIDTH, 4: counter width in bits; must be ≥ 1.
- MAX, 2**WIDTH-1: highest count value; range is 0..MAX; must satisfy 1 ≤ MAX ≤ 2**WIDTH-1.
- SATURATE, 0: 0 = wrap at limits, 1 = hold at limits.
- PRESCALE, 1: number of enabled cycles per count step; must be ≥ 1; 1 = step on every enabled cycle.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  one clock `clk`; reset `rst` is synchronous and active-high.
- en  input  1  count enable; advances the prescaler.
- up  input  1  direction: 1 = increment, 0 = decrement; sampled on the step cycle.
- load  input  1  synchronous load of `load_val`.
- load_val  input  WIDTH  load value; values > MAX are clamped to MAX.
- clear  input  1  synchronous clear to 0.
- count  output  WIDTH  current count, registered.
- wrap  output  1  one-cycle pulse, registered; the last step crossed a limit (wrap mode only).
- sat  output  1  registered; the last step attempt was blocked at a limit (saturate mode only).
- at_max  output  1  combinational decode: count == MAX.
- at_min  output  1  combinational decode: count == 0.

## Operation
- Priority, highest first: rst > clear > load > step > hold.
- **rst:** count=0, prescaler=0, wrap=0, sat=0.
- **clear:** count=0, prescaler=0, wrap=0, sat=0.
- **load:**
  - count = min(load_val, MAX); prescaler=0, wrap=0, sat=0.
  - `en` is ignored in the load cycle.
- **Prescaler:**
  - Internal counter of width clog2(PRESCALE), minimum 1 bit.
  - On each en=1 cycle with no clear/load: if prescaler == PRESCALE-1, a step is taken and the prescaler goes to 0; otherwise the prescaler increments.
  - en=0 freezes the prescaler; it is not reset.
- **Step, up=1:**
  - count < MAX: count+1.
  - count == MAX with SATURATE=0: count=0, wrap=1.
  - count == MAX with SATURATE=1: count holds, sat=1.
- **Step, up=0:**
  - count > 0: count-1.
  - count == 0 with SATURATE=0: count=MAX, wrap=1.
  - count == 0 with SATURATE=1: count holds, sat=1.
- wrap and sat are 0 in every cycle not described above; both are single-cycle flags.
- Arithmetic is WIDTH bits. There is no overflow past MAX, because the limit compare precedes the +1/-1.
- A direction change between steps is legal and takes effect on the next step.

## Timing
- **Latency:** inputs sampled at edge N; count, wrap and sat reflect the result after edge N. at_max and at_min follow count in the same cycle.
- **Step cadence:** with en held high, one step every PRESCALE cycles. The first step comes PRESCALE edges after rst, clear or load.
- **Reset values:** count=0, wrap=0, sat=0, at_min=1, at_max=0.
- **Reset mid-operation:** rst overrides everything on that edge; the prescaler phase is lost.
- **Simultaneous events:**
  - clear with load: clear wins.
  - load with a step-eligible en: load wins, no step, prescaler=0.
- **Degenerate range:** with MAX=1 and wrap mode, every step toggles count and asserts wrap on each 1→0 (up) or 0→1 (down) transition.

## Test plan
- **Reset/basic up** (WIDTH=4, MAX=15, PRESCALE=1): rst 1 cycle, en=1, up=1 for 17 cycles -> count 1..15, 0, 1; wrap=1 only in the cycle count becomes 0; at_max=1 only while count=15.
- **Down wrap and non-power-of-2 MAX** (MAX=9): load_val=2, then en=1, up=0 -> count 2, 1, 0, 9, 8; wrap pulses with count=9.
- **Saturate** (SATURATE=1, MAX=5): load 4, en=1, up=1 for 3 cycles -> count 5, 5, 5; sat=1 in the 2nd and 3rd cycles; then up=0 -> count 4, sat=0.
- **Prescaler** (PRESCALE=3): en=1 continuously -> count increments on edges 3, 6, 9 after rst. Drop en for 2 cycles after the 1st prescaler tick -> the next step is delayed by exactly 2 cycles.
- **Priority/clamp** (MAX=9): same cycle clear=1, load=1, load_val=7 -> count=0. Next cycle load=1, load_val=15 -> count=9. Load=1 with en=1 while the step is eligible -> count=load value, no step, next step PRESCALE cycles later.
- **Mid-run reset:** count=6 with prescaler phase 1, assert rst -> count=0 and wrap=sat=0 after that edge; the first subsequent step occurs PRESCALE enabled cycles later.
